wb_port_arbiter: RTL and testbench

Shares the single register-file write port between the in-order writeback stage and the out-of-band long-latency unit (multiply/divide) that completes asynchronously to the pipeline. Pipeline writebacks always win. Long-latency results queue in a small FIFO and drain into idle write slots. Younger pipeline writes cancel stale queued results to the same register. An optional starvation counter asks the pipeline for a bubble when the queue head waits too long.

---
 rtl/wb_port_arbiter.sv | 90 +++++++++
 tb/tb_wb_port_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between pipeline writeback and queued long-latency results.
// Define WB_ARB_STARVE_EN to enable the head-starvation bubble request on pipe_stall.
module wb_port_arbiter #(
  parameter int DEPTH = 2,
  parameter int DATA_W = 64,
  parameter int STARVE_MAX = 4
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              pipe_valid,
  input  logic              pipe_wen,
  input  logic [4:0]        pipe_dst,
  input  logic [DATA_W-1:0] pipe_data,
  input  logic              lu_valid,
  output logic              lu_ready,
  input  logic [4:0]        lu_dst,
  input  logic [DATA_W-1:0] lu_data,
  output logic              rf_wen,
  output logic [4:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [31:0]       pending_mask,
  output logic              pipe_stall
);
  localparam int AW = $clog2(DEPTH);
  logic [4:0]        q_dst  [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [DEPTH-1:0]  q_live;
  logic [AW-1:0]     head, tail;
  logic [AW:0]       count;
  logic              pipe_wr, enq, empty, head_live, pop;
  assign pipe_wr   = pipe_valid && pipe_wen && pipe_dst != 5'd0;
  assign lu_ready  = count < (AW+1)'(DEPTH);
  // results to r0 or shadowed by a same-cycle pipe write are accepted but dropped
  assign enq       = lu_valid && lu_ready && lu_dst != 5'd0 && !(pipe_wr && lu_dst == pipe_dst);
  assign empty     = count == '0;
  assign head_live = !empty && q_live[head];
  assign pop       = !empty && (!q_live[head] || !pipe_wr);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      q_live   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_dst[i]  <= '0;
        q_data[i] <= '0;
      end
    end else begin
      rf_wen <= pipe_wr || head_live;
      if (pipe_wr) begin
        rf_waddr <= pipe_dst;
        rf_wdata <= pipe_data;
      end else if (head_live) begin
        rf_waddr <= q_dst[head];
        rf_wdata <= q_data[head];
      end
      for (int i = 0; i < DEPTH; i++)
        if (pipe_wr && q_dst[i] == pipe_dst) q_live[i] <= 1'b0;
      if (pop) begin
        q_live[head] <= 1'b0;
        head         <= head + AW'(1);
      end
      if (enq) begin
        q_live[tail] <= 1'b1;
        q_dst[tail]  <= lu_dst;
        q_data[tail] <= lu_data;
        tail         <= tail + AW'(1);
      end
      count <= count + (AW+1)'(enq) - (AW+1)'(pop);
    end
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (q_live[i]) pending_mask[q_dst[i]] = 1'b1;
    pending_mask[0] = 1'b0;
  end
`ifdef WB_ARB_STARVE_EN
  logic [3:0] starve;
  always_ff @(posedge clk or negedge reset)
    if (!reset) starve <= '0;
    else if (pop || empty) starve <= '0;
    else if (starve != 4'(STARVE_MAX)) starve <= starve + 4'd1;
  assign pipe_stall = starve == 4'(STARVE_MAX);
`else
  assign pipe_stall = 1'b0;
`endif
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed and randomized checks of wb_port_arbiter against a queue-based reference model.
module tb_wb_port_arbiter;
  localparam int DEPTH = 2;
  localparam int DATA_W = 64;
  localparam int STARVE_MAX = 4;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic pipe_valid = 1'b0, pipe_wen = 1'b0, lu_valid = 1'b0;
  logic [4:0] pipe_dst = '0, lu_dst = '0;
  logic [DATA_W-1:0] pipe_data = '0, lu_data = '0;
  logic lu_ready, rf_wen, pipe_stall;
  logic [4:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [31:0] pending_mask;
  always #5 clk = ~clk;
  wb_port_arbiter #(.DEPTH(DEPTH), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .pipe_valid(pipe_valid), .pipe_wen(pipe_wen), .pipe_dst(pipe_dst), .pipe_data(pipe_data),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_dst(lu_dst), .lu_data(lu_data),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pending_mask(pending_mask), .pipe_stall(pipe_stall)
  );
  typedef struct {
    logic [4:0]  dst;
    logic [63:0] data;
    bit          live;
  } ent_t;
  ent_t q[$];
  int checks = 0, errors = 0, starve_m = 0;
  logic m_wen = 1'b0;
  logic [4:0] m_waddr = '0;
  logic [63:0] m_wdata = '0;
  bit last_acc;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] mask_m();
    logic [31:0] m = '0;
    foreach (q[i]) if (q[i].live) m[q[i].dst] = 1'b1;
    return m;
  endfunction
  function automatic logic stall_m();
`ifdef WB_ARB_STARVE_EN
    return starve_m == STARVE_MAX;
`else
    return 1'b0;
`endif
  endfunction
  task automatic step(input logic pv, input logic pwen, input logic [4:0] pd, input logic [63:0] pdat,
                      input logic lv, input logic [4:0] ld, input logic [63:0] ldat);
    bit pw, rdy, popd, was_empty;
    ent_t e;
    pipe_valid = pv; pipe_wen = pwen; pipe_dst = pd; pipe_data = pdat;
    lu_valid = lv; lu_dst = ld; lu_data = ldat;
    #1;
    pw = pv && pwen && pd != 5'd0;
    rdy = q.size() < DEPTH;
    was_empty = q.size() == 0;
    chk("lu_ready", lu_ready, rdy);
    chk("pending_mask", pending_mask, mask_m());
    chk("pipe_stall", pipe_stall, stall_m());
    last_acc = lv && rdy;
    popd = 0;
    if (pw) begin
      m_wen = 1'b1; m_waddr = pd; m_wdata = pdat;
    end else if (!was_empty && q[0].live) begin
      m_wen = 1'b1; m_waddr = q[0].dst; m_wdata = q[0].data;
      void'(q.pop_front());
      popd = 1;
    end else m_wen = 1'b0;
    if (!popd && q.size() > 0 && !q[0].live) begin
      void'(q.pop_front());
      popd = 1;
    end
    starve_m = (popd || was_empty) ? 0 : (starve_m < STARVE_MAX ? starve_m + 1 : starve_m);
    if (pw) foreach (q[i]) if (q[i].dst == pd) q[i].live = 0;
    if (last_acc && ld != 5'd0 && !(pw && ld == pd)) begin
      e.dst = ld; e.data = ldat; e.live = 1;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    chk("rf_wen", rf_wen, m_wen);
    chk("rf_waddr", rf_waddr, m_waddr);
    chk("rf_wdata", rf_wdata, m_wdata);
  endtask
  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_lu_ready", lu_ready, 1);
    chk("rst_pending", pending_mask, 0);
    chk("rst_rf_wen", rf_wen, 0);
    chk("rst_rf_waddr", rf_waddr, 0);
    chk("rst_rf_wdata", rf_wdata, 0);
    chk("rst_stall", pipe_stall, 0);
    q.delete();
    starve_m = 0;
    m_wen = 1'b0; m_waddr = '0; m_wdata = '0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask
  initial begin
    logic [4:0] offs [3];
    int k;
    logic have;
    logic [4:0] rd;
    logic [63:0] rdat;
    #2;
    do_reset();
    // single result drains into an idle port two edges after the offer
    step(0, 0, 0, 0, 1, 5, 64'hAA);
    chk("t1_pend5", pending_mask[5], 1);
    idle();
    chk("t1_wen", rf_wen, 1);
    chk("t1_waddr", rf_waddr, 5);
    chk("t1_wdata", rf_wdata, 64'hAA);
    chk("t1_pend5_off", pending_mask[5], 0);
    idle();
    // full queue under continuous pipe writes, then in-order drain
    offs[0] = 7; offs[1] = 8; offs[2] = 9;
    k = 0;
    for (int c = 0; c < 4; c++) begin
      step(1, 1, 3, 64'h300 + 64'(c), 1, offs[k], 64'h700 + 64'(k));
      if (last_acc) k++;
    end
    chk("t2_accepted", k, 2);
    chk("t2_not_ready", lu_ready, 0);
    while (k < 3) begin
      step(0, 0, 0, 0, 1, offs[k], 64'h700 + 64'(k));
      if (last_acc) k++;
    end
    idle(); idle(); idle();
    chk("t2_empty", pending_mask, 0);
    // younger pipe write kills a queued result
    step(1, 1, 3, 64'h33, 1, 6, 64'h11);
    chk("t3_pend6", pending_mask[6], 1);
    step(1, 1, 6, 64'h22, 0, 0, 0);
    chk("t3_pend6_off", pending_mask[6], 0);
    chk("t3_wdata", rf_wdata, 64'h22);
    idle(); idle(); idle();
    // r0 result and same-register result are consumed and dropped
    step(1, 1, 4, 64'h44, 1, 0, 64'h99);
    step(1, 1, 4, 64'h45, 1, 4, 64'h98);
    chk("t4_pend", pending_mask, 0);
    chk("t4_ready", lu_ready, 1);
    idle(); idle();
    // starvation bubble request
    step(1, 1, 3, 64'h50, 1, 10, 64'hBB);
    for (int c = 0; c < 4; c++) step(1, 1, 3, 64'h51 + 64'(c), 0, 0, 0);
`ifdef WB_ARB_STARVE_EN
    chk("t5_stall_hi", pipe_stall, 1);
`else
    chk("t5_stall_lo", pipe_stall, 0);
`endif
    idle();
    chk("t5_drain_addr", rf_waddr, 10);
    chk("t5_stall_off", pipe_stall, 0);
    idle();
    // reset with queued entries loses them
    step(1, 1, 3, 64'h60, 1, 12, 64'hC1);
    step(1, 1, 3, 64'h61, 1, 13, 64'hC2);
    chk("t6_pend", pending_mask, 32'h3000);
    do_reset();
    for (int c = 0; c < 4; c++) idle();
    // randomized traffic with the LU holding its offer until accepted
    have = 0; rd = 0; rdat = 0;
    for (int c = 0; c < 600; c++) begin
      if (!have) begin
        have = $urandom_range(0, 99) < 55;
        rd = 5'($urandom_range(0, 7));
        rdat = {$urandom, $urandom};
      end
      step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 85, 5'($urandom_range(0, 7)),
           {$urandom, $urandom}, have, rd, rdat);
      if (last_acc) have = 0;
    end
    for (int c = 0; c < 6; c++) idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
